// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - MIPS R-type funct codes handled by the unit
//   - FSM state encoding and datapath step mode
//   - divide-by-zero result constants
package muldiv_pkg;

  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMthi  = 6'b010001;
  localparam logic [5:0] FunctMflo  = 6'b010010;
  localparam logic [5:0] FunctMtlo  = 6'b010011;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctDiv   = 6'b011010;
  localparam logic [5:0] FunctDivu  = 6'b011011;

  // Divide by zero: LO is filled with this bit, HI takes the dividend unchanged.
  localparam logic DivZeroLoFill = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StPrep,
    StRun,
    StFix
  } mdu_state_e;

  typedef enum logic {
    StepMul,
    StepDiv
  } step_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative multiply/divide datapath.
//   mode_i  StepMul: shift-add, multiplier in acc_i[W-1:0], partial product in acc_i[2W-1:W]
//           StepDiv: restoring shift-subtract, remainder in acc_i[2W-1:W], quotient
//                    bits shifted into acc_i[W-1:0]
//   acc_i   2*WIDTH accumulator before the iteration
//   opnd_i  multiplicand (mul) or divisor (div) magnitude
//   acc_o   accumulator after the iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  step_mode_e         mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    // Extra top bit holds the add carry, which the right shift brings back in.
    sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    // Shifted partial remainder is WIDTH+1 bits; diff[WIDTH] set means borrow.
    diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
    acc_o = acc_i;
    unique case (mode_i)
      StepMul: begin
        if (acc_i[0]) acc_o = {sum, acc_i[WIDTH-1:1]};
        else          acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
      StepDiv: begin
        if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        else              acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Handles mult, multu, div, divu, mfhi, mflo, mthi, mtlo. mult/div run
// IDLE -> PREP -> RUN (WIDTH cycles) -> FIX -> IDLE.
// Build option: MULDIV_DIV_EN enables div/divu; without it they decode as illegal.
// Ports:
//   clk_i      clock, rising edge
//   reset_i    synchronous active-high reset
//   start_i    current instruction is an MDU candidate
//   funct_i    instruction funct field
//   a_i, b_i   rs / rt operands
//   result_o   HI for mfhi, LO for mflo, else 0
//   stall_o    MDU op presented while busy
//   busy_o     mult/div in flight
//   done_o     pulse in the cycle HI/LO take the result
//   illegal_o  start with a non-MDU funct
//   hi_o, lo_o architectural HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  mdu_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               div_q, div_d;
  logic               signed_q, signed_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Funct decode
  logic f_mfhi, f_mthi, f_mflo, f_mtlo, f_mul, f_div, f_signed, f_mdu;

  always_comb begin
    f_mfhi   = (funct_i == FunctMfhi);
    f_mthi   = (funct_i == FunctMthi);
    f_mflo   = (funct_i == FunctMflo);
    f_mtlo   = (funct_i == FunctMtlo);
    f_mul    = (funct_i == FunctMult) || (funct_i == FunctMultu);
`ifdef MULDIV_DIV_EN
    f_div    = (funct_i == FunctDiv) || (funct_i == FunctDivu);
`else
    f_div    = 1'b0;
`endif
    f_signed = (funct_i == FunctMult) || (funct_i == FunctDiv);
    f_mdu    = f_mfhi | f_mthi | f_mflo | f_mtlo | f_mul | f_div;
  end

  // Operand magnitudes and signs, used only in PREP
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    a_neg = signed_q & a_q[WIDTH-1];
    b_neg = signed_q & b_q[WIDTH-1];
    mag_a = a_neg ? (~a_q + 1'b1) : a_q;
    mag_b = b_neg ? (~b_q + 1'b1) : b_q;
  end

  step_mode_e         step_mode;
  logic [2*WIDTH-1:0] step_acc;

  assign step_mode = div_q ? StepDiv : StepMul;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode_i (step_mode),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  // Sign fixup of the finished accumulator
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    prod = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    quot = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    b_d      = b_q;
    div_d    = div_q;
    signed_d = signed_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && f_mdu) begin
          if (f_mthi) hi_d = a_i;
          if (f_mtlo) lo_d = a_i;
          if (f_mul || f_div) begin
            a_d      = a_i;
            b_d      = b_i;
            div_d    = f_div;
            signed_d = f_signed;
            state_d  = StPrep;
          end
        end
      end
      StPrep: begin
        neg_lo_d = a_neg ^ b_neg;
        neg_hi_d = div_q & a_neg;
        if (div_q) begin
          acc_d  = {{WIDTH{1'b0}}, mag_a};
          opnd_d = mag_b;
        end else begin
          acc_d  = {{WIDTH{1'b0}}, mag_b};
          opnd_d = mag_a;
        end
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = {WIDTH{DivZeroLoFill}};
          end else begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
`else
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      signed_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      div_q    <= div_d;
      signed_q <= signed_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    busy_o    = (state_q != StIdle);
    done_o    = (state_q == StFix);
    stall_o   = start_i & f_mdu & busy_o;
    illegal_o = start_i & ~f_mdu;
    result_o  = '0;
    if (start_i && f_mfhi)      result_o = hi_q;
    else if (start_i && f_mflo) result_o = lo_q;
    hi_o = hi_q;
    lo_o = lo_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at WIDTH=32.
// Inputs change #1 after a rising edge; outputs are sampled on the falling edge.
module tb_muldiv_unit;

  localparam logic [5:0] FMfhi  = 6'b010000;
  localparam logic [5:0] FMthi  = 6'b010001;
  localparam logic [5:0] FMflo  = 6'b010010;
  localparam logic [5:0] FMult  = 6'b011000;
  localparam logic [5:0] FMultu = 6'b011001;
  localparam logic [5:0] FDiv   = 6'b011010;
  localparam logic [5:0] FDivu  = 6'b011011;
  localparam logic [5:0] FAdd   = 6'b100000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic [31:0] result, hi, lo;
  logic        stall, busy, done, illegal;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (start),
    .funct_i   (funct),
    .a_i       (a),
    .b_i       (b),
    .result_o  (result),
    .stall_o   (stall),
    .busy_o    (busy),
    .done_o    (done),
    .illegal_o (illegal),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue a mult/div from a falling edge, scramble operands after acceptance,
  // then count busy cycles and done pulses until busy drops (bounded).
  task automatic run_long(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          output int busy_cycles, output int done_cnt);
    start = 1'b1; funct = f; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEADBEEF; b = 32'h13572468;
    busy_cycles = 0;
    done_cnt    = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (!busy) break;
    end
  endtask

  task automatic run_div(input string tag, input logic [5:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int bc, dc;
`ifdef MULDIV_DIV_EN
    run_long(f, av, bv, bc, dc);
    check_eq({tag, "_busy"}, 64'(bc), 64'd34);
    check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
`else
    logic [31:0] old_hi, old_lo;
    old_hi = hi; old_lo = lo;
    start = 1'b1; funct = f; a = av; b = bv;
    @(negedge clk);
    check_eq({tag, "_illegal"}, 64'(illegal), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq({tag, "_nobusy"}, 64'(busy), 64'd0);
    check_eq({tag, "_hi_keep"}, 64'(hi), 64'(old_hi));
    check_eq({tag, "_lo_keep"}, 64'(lo), 64'(old_lo));
    bc = 0; dc = 0;
`endif
  endtask

  initial begin
    int bc, dc, stall_cnt;
    reset = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);

    // Signed multiply: -1 * 2 = -2 across 64 bits
    run_long(FMult, 32'hFFFFFFFF, 32'd2, bc, dc);
    check_eq("mult_busy", 64'(bc), 64'd34);
    check_eq("mult_done", 64'(dc), 64'd1);
    check_eq("mult_hi", 64'(hi), 64'hFFFFFFFF);
    check_eq("mult_lo", 64'(lo), 64'hFFFFFFFE);

    run_long(FMultu, 32'hFFFFFFFF, 32'd2, bc, dc);
    check_eq("multu_hi", 64'(hi), 64'h00000001);
    check_eq("multu_lo", 64'(lo), 64'hFFFFFFFE);

    // Signed negative by negative: -3 * -5 = 15
    run_long(FMult, 32'hFFFFFFFD, 32'hFFFFFFFB, bc, dc);
    check_eq("mult_nn_hi", 64'(hi), 64'd0);
    check_eq("mult_nn_lo", 64'(lo), 64'd15);

    run_div("div_neg", FDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_div("divu_zero", FDivu, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run_div("div_ovf", FDiv, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_div("divu_basic", FDivu, 32'd100, 32'd7, 32'd2, 32'd14);

    // mthi when idle updates HI at the next edge, no stall
    start = 1'b1; funct = FMthi; a = 32'hA5A5A5A5;
    @(negedge clk);
    check_eq("mthi_stall", 64'(stall), 64'd0);
    check_eq("mthi_illegal", 64'(illegal), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("mthi_hi", 64'(hi), 64'hA5A5A5A5);

    // mflo issued 5 cycles after a mult start stalls until FIX completes
    start = 1'b1; funct = FMult; a = 32'h10; b = 32'h20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // illegal op during the run: flagged, no stall
    start = 1'b1; funct = FAdd;
    @(negedge clk);
    check_eq("ill_busy_flag", 64'(illegal), 64'd1);
    check_eq("ill_busy_stall", 64'(stall), 64'd0);
    funct = FMflo;
    @(negedge clk);
    check_eq("mflo_stall_on", 64'(stall), 64'd1);
    stall_cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      stall_cnt++;
    end
    check_eq("mflo_stall_len", 64'(stall_cnt), 64'd29);
    check_eq("mflo_result", 64'(result), 64'h200);
    funct = FMfhi;
    #1;
    check_eq("mfhi_result", 64'(result), 64'h0);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("noop_result", 64'(result), 64'h0);

    // Reset during RUN clears everything; next multu works
    start = 1'b1; funct = FMultu; a = 32'h7; b = 32'h9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_hi", 64'(hi), 64'd0);
    check_eq("midrst_lo", 64'(lo), 64'd0);
    run_long(FMultu, 32'd3, 32'd5, bc, dc);
    check_eq("post_rst_busy", 64'(bc), 64'd34);
    check_eq("post_rst_lo", 64'(lo), 64'd15);
    check_eq("post_rst_hi", 64'(hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
